// File: rtl/rpi1031_sense_pkg.sv
// Shared types and helpers for the RPI1031 tilt-sensor front end.
// Event record layout, event kinds, queue depth and ms-to-cycle conversion.
package rpi_sense_pkg;

  typedef struct packed {
    logic [1:0] state;
    logic [7:0] seq;
    logic       kind;
  } rpi_evt_t;

  localparam logic EVT_CHANGE   = 1'b0;
  localparam logic EVT_PERIODIC = 1'b1;
  localparam int   QUEUE_DEPTH  = 2;

  function automatic int unsigned ms_to_cycles(input int unsigned clk_mhz, input int unsigned ms);
    return clk_mhz * 1000 * ms;
  endfunction

endpackage

// File: rtl/rpi1031_sense_if.sv
// Event handshake between the sensor front end (master) and the UART sender (slave).
// Head fields are held stable by the master while evt_valid && !evt_ready.
interface rpi1031_sense_if;
  import rpi_sense_pkg::*;

  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_state;
  logic [7:0] evt_seq;
  logic       evt_kind;
  logic       evt_overflow;

  modport master (
    output evt_valid, evt_state, evt_seq, evt_kind, evt_overflow,
    input  evt_ready
  );

  modport slave (
    input  evt_valid, evt_state, evt_seq, evt_kind, evt_overflow,
    output evt_ready
  );

endinterface

// File: rtl/rpi1031_sense_debounce.sv
// rpi_debounce: 2-FF sync then shared-counter debounce; stable updates 3+DEB_CYCLES cycles after a pin edge.
// chg pulses for one cycle alongside the new stable value; no backpressure, it never stalls.
module rpi_debounce #(
  parameter int unsigned W          = 2,
  parameter int unsigned DEB_CYCLES = 1000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] raw,
  output logic [W-1:0] stable,
  output logic         chg
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [W-1:0]  sync_d;
  logic [W-1:0]  sync_q;
  logic [W-1:0]  cand;
  logic [CW-1:0] cnt;

  // Any movement of the synchronised vector restarts the whole window, so a
  // multi-bit transition is accepted only once every bit has settled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_d <= '0;
      sync_q <= '0;
      cand   <= '0;
      cnt    <= '0;
      stable <= '0;
      chg    <= 1'b0;
    end else begin
      sync_d <= raw;
      sync_q <= sync_d;
      chg    <= 1'b0;
      if (sync_q != cand) begin
        cand <= sync_q;
        cnt  <= '0;
      end else if (cand != stable) begin
        if (cnt == CNT_LAST) begin
          stable <= cand;
          cnt    <= '0;
          chg    <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/rpi1031_sense.sv
// rpi1031_sense: debounced tilt state plus a 2-entry FWFT event queue; optional periodic reports under RPI_PERIODIC_EN.
// Pin edge to stable_state 3+DEB_CYCLES cycles, evt_valid one later; full queue without a pop drops the event and sets evt_overflow.
module rpi1031_sense
  import rpi_sense_pkg::*;
#(
  parameter int unsigned CLK_FRE     = 50,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned PERIOD_MS   = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       RPI1031_state,
  output logic [1:0]       stable_state,
  rpi1031_sense_if.master  evt
);

  localparam int unsigned DEB_RAW    = ms_to_cycles(CLK_FRE, DEBOUNCE_MS);
  localparam int unsigned DEB_CYCLES = (DEB_RAW == 0) ? 1 : DEB_RAW;
  localparam int          QW         = $clog2(QUEUE_DEPTH);

  logic chg;

  rpi_debounce #(
    .W          (2),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw    (RPI1031_state),
    .stable (stable_state),
    .chg    (chg)
  );

  logic per_fire;

`ifdef RPI_PERIODIC_EN
  localparam int unsigned PER_RAW    = ms_to_cycles(CLK_FRE, PERIOD_MS);
  localparam int unsigned PER_CYCLES = (PER_RAW == 0) ? 1 : PER_RAW;
  localparam int          TW         = (PER_CYCLES > 1) ? $clog2(PER_CYCLES) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(PER_CYCLES - 1);

  logic [TW-1:0] tmr;

  // A change event takes the slot and restarts the period instead.
  assign per_fire = (tmr == TMR_LAST) && !chg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr <= '0;
    end else if (chg || (tmr == TMR_LAST)) begin
      tmr <= '0;
    end else begin
      tmr <= tmr + 1'b1;
    end
  end
`else
  assign per_fire = 1'b0;
`endif

  rpi_evt_t       q_mem [QUEUE_DEPTH];
  logic [QW-1:0]  wr_ptr;
  logic [QW-1:0]  rd_ptr;
  logic [QW:0]    count;
  logic [7:0]     seq;
  logic           overflow;
  logic           push;
  logic           pop;
  logic           push_ok;
  rpi_evt_t       push_dat;
  rpi_evt_t       head;

  assign push    = chg | per_fire;
  assign pop     = (count != '0) && evt.evt_ready;
  // Full queue still accepts a push when the head leaves in the same cycle.
  assign push_ok = push && ((count != (QW+1)'(QUEUE_DEPTH)) || pop);

  always_comb begin
    push_dat       = '0;
    push_dat.state = stable_state;
    push_dat.seq   = seq;
    push_dat.kind  = per_fire ? EVT_PERIODIC : EVT_CHANGE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_mem[i] <= '0;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      seq      <= '0;
      overflow <= 1'b0;
    end else begin
      // Dropped events still consume a number so the consumer can see the gap.
      if (push) begin
        seq <= seq + 8'd1;
      end
      if (push_ok) begin
        q_mem[wr_ptr] <= push_dat;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (push && !push_ok) begin
        overflow <= 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head             = q_mem[rd_ptr];
  assign evt.evt_valid    = (count != '0);
  assign evt.evt_state    = head.state;
  assign evt.evt_seq      = head.seq;
  assign evt.evt_kind     = head.kind;
  assign evt.evt_overflow = overflow;

endmodule
